// File: rtl/stepper_phase_decoder.sv
// stepper_phase_decoder
// Watches the one-hot coil drive of a 4-phase stepper and reconstructs motion:
// decoded phase, step pulses with direction, a signed wrapping position count,
// illegal-pattern and skipped-phase errors, and a "moving" indication.
//
// Ports:
//   clk, rst     - clock; synchronous active-high reset
//   coil_in      - coil pattern (1000=ph0, 0100=ph1, 0010=ph2, 0001=ph3, 0000=off)
//   clr_pos      - synchronous clear of pos (wins over a same-cycle step)
//   pos          - signed step position, wraps silently
//   phase        - last valid decoded phase
//   phase_valid  - a reference phase is held (LOCKED or OFF)
//   energized    - coils driven with a valid phase (LOCKED)
//   step_pulse   - one-cycle pulse per decoded step
//   step_dir     - direction of last step: 0=CW, 1=CCW
//   moving       - a step occurred within the last STALL_CYCLES cycles
//   err_illegal  - one-cycle pulse on entry into an illegal pattern
//   err_skip     - one-cycle pulse on a two-phase jump
//   err_count    - saturating count of error pulses
module stepper_phase_decoder #(
    parameter int unsigned POS_W        = 16,
    parameter int unsigned STALL_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              coil_in,
    input  logic                    clr_pos,
    output logic signed [POS_W-1:0] pos,
    output logic [1:0]              phase,
    output logic                    phase_valid,
    output logic                    energized,
    output logic                    step_pulse,
    output logic                    step_dir,
    output logic                    moving,
    output logic                    err_illegal,
    output logic                    err_skip,
    output logic [7:0]              err_count
);

    localparam int unsigned        IDLE_W   = $clog2(STALL_CYCLES + 1);
    localparam logic [IDLE_W-1:0]  IDLE_MAX = IDLE_W'(STALL_CYCLES);

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKED,
        OFF
    } state_t;

    state_t            state;
    logic [3:0]        coil_q;
    logic [3:0]        last_q;
    logic [1:0]        ref_q;
    logic [IDLE_W-1:0] idle_cnt;

    logic       evt;
    logic       pat_valid;
    logic       pat_off;
    logic [1:0] pat_phase;
    logic [1:0] delta;
    logic       have_ref;
    logic       do_cw;
    logic       do_ccw;
    logic       do_skip;
    logic       do_illegal;
    logic       do_step;

    // Event detection and decode of the captured pattern against the reference.
    always_comb begin
        pat_valid = 1'b1;
        pat_phase = '0;
        case (coil_q)
            4'b1000: pat_phase = 2'd0;
            4'b0100: pat_phase = 2'd1;
            4'b0010: pat_phase = 2'd2;
            4'b0001: pat_phase = 2'd3;
            default: pat_valid = 1'b0;
        endcase
        pat_off    = (coil_q == 4'b0000);
        evt        = (coil_q != last_q);
        // 2-bit subtraction gives (p - ref) mod 4 directly
        delta      = pat_phase - ref_q;
        have_ref   = (state != UNLOCKED);
        do_cw      = evt && pat_valid && have_ref && (delta == 2'd1);
        do_ccw     = evt && pat_valid && have_ref && (delta == 2'd3);
        do_skip    = evt && pat_valid && have_ref && (delta == 2'd2);
        do_illegal = evt && !pat_valid && !pat_off;
        do_step    = do_cw || do_ccw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coil_q      <= '0;
            last_q      <= '0;
            state       <= UNLOCKED;
            ref_q       <= '0;
            pos         <= '0;
            step_pulse  <= 1'b0;
            step_dir    <= 1'b0;
            err_illegal <= 1'b0;
            err_skip    <= 1'b0;
            err_count   <= '0;
            idle_cnt    <= IDLE_MAX;
        end else begin
            coil_q      <= coil_in;
            last_q      <= coil_q;
            step_pulse  <= do_step;
            err_illegal <= do_illegal;
            err_skip    <= do_skip;

            if (do_step)
                step_dir <= do_ccw;

            if (evt) begin
                if (do_illegal) begin
                    state <= UNLOCKED;
                end else if (pat_valid) begin
                    ref_q <= pat_phase;
                    state <= LOCKED;
                end else if (state == LOCKED) begin
                    // de-energized: keep the reference so a resume can be tracked
                    state <= OFF;
                end
            end

            if (clr_pos)
                pos <= '0;
            else if (do_cw)
                pos <= pos + POS_W'(1);
            else if (do_ccw)
                pos <= pos - POS_W'(1);

            if (do_step)
                idle_cnt <= '0;
            else if (idle_cnt < IDLE_MAX)
                idle_cnt <= idle_cnt + IDLE_W'(1);

            if ((do_illegal || do_skip) && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end

    // All derived from registers only; no input-to-output combinational path.
    assign phase       = ref_q;
    assign phase_valid = (state != UNLOCKED);
    assign energized   = (state == LOCKED);
    assign moving      = (idle_cnt < IDLE_MAX);

endmodule
